// File: rtl/tt_um_uwasic_onboarding_miranda_pkg.sv
// Shared constants for the SPI-controlled output/PWM block: register map, frame layout, frame length.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tt_um_uwasic_onboarding_miranda_pkg;

    // Frame length in SCLK bits and the width of the saturating bit counter
    localparam int FRAME_LEN = 16;
    localparam int CNT_W     = 5;

    // Frame field positions: {rw, addr[6:0], data[7:0]}
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    // Register map
    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    // Decoded view of a received frame
    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } frame_t;

    // A frame is committed only when it is complete, a write, and inside the map
    function automatic logic frame_ok(input frame_t f, input logic [CNT_W-1:0] cnt,
                                      input logic [6:0] max_addr);
        return (cnt == CNT_W'(FRAME_LEN)) && f.rw && (f.addr <= max_addr);
    endfunction

endpackage

// File: rtl/tt_um_uwasic_onboarding_miranda_spi_peripheral.sv
// Write-only SPI (mode 0) slave: synchronizes SCLK/COPI/nCS, shifts a 16-bit frame, updates the register file.
// Latency: register updated 3 clk edges after the raw nCS rise (2 sync flops + 1 commit edge).
// Backpressure: none; SPI has no flow control, malformed frames are silently dropped.
module spi_peripheral
    import tt_um_uwasic_onboarding_miranda_pkg::*;
#(
    parameter int MAX_ADDR = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        copi,
    input  logic        ncs,
    output logic [15:0] en_out,
    output logic [15:0] en_pwm,
    output logic [7:0]  duty
);

    // [0],[1] form the 2-flop synchronizer, [2] holds the previous synchronized value for edge detection
    logic [2:0] sclk_sync;
    logic [2:0] copi_sync;
    logic [2:0] ncs_sync;

    logic [FRAME_LEN-1:0] shift_reg;
    logic [CNT_W-1:0]     bit_cnt;

    logic   sclk_rise;
    logic   ncs_rise;
    logic   ncs_fall;
    logic   ncs_low;
    logic   copi_bit;
    frame_t frame;

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign ncs_rise  = ncs_sync[1] & ~ncs_sync[2];
    assign ncs_fall  = ~ncs_sync[1] & ncs_sync[2];
    assign ncs_low   = ~ncs_sync[1];
    assign copi_bit  = copi_sync[1];
    assign frame     = frame_t'(shift_reg);

    // Bring the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            copi_sync <= {copi_sync[1:0], copi};
            ncs_sync  <= {ncs_sync[1:0], ncs};
        end
    end

    // Shift MSB-first while selected; bits beyond the frame length are ignored so the count saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (ncs_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (ncs_low && sclk_rise && (bit_cnt != CNT_W'(FRAME_LEN))) begin
            shift_reg <= {shift_reg[FRAME_LEN-2:0], copi_bit};
            bit_cnt   <= bit_cnt + 1'b1;
        end
    end

    // Commit a well-formed write frame on deselect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_out <= '0;
            en_pwm <= '0;
            duty   <= '0;
        end else if (ncs_rise && frame_ok(frame, bit_cnt, 7'(MAX_ADDR))) begin
            case (frame.addr)
                ADDR_EN_OUT_LO: en_out[7:0]  <= frame.data;
                ADDR_EN_OUT_HI: en_out[15:8] <= frame.data;
                ADDR_EN_PWM_LO: en_pwm[7:0]  <= frame.data;
                ADDR_EN_PWM_HI: en_pwm[15:8] <= frame.data;
                ADDR_DUTY:      duty         <= frame.data;
                default:        ;
            endcase
        end
    end

endmodule

// File: rtl/tt_um_uwasic_onboarding_miranda.sv
// Top level: SPI register file driving 16 output channels, optionally gated by one shared PWM (macro UWASIC_PWM_EN).
// Latency: committed write reaches the pins 4 clk edges after the raw nCS rise.
// Backpressure: none; outputs are free-running registers.
module tt_um_uwasic_onboarding_miranda
    import tt_um_uwasic_onboarding_miranda_pkg::*;
#(
    parameter int PWM_PRESCALE = 13,
    parameter int MAX_ADDR     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // rst_n is active-high despite its name
    logic rst;
    assign rst = rst_n;

    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] chan;

    spi_peripheral #(
        .MAX_ADDR (MAX_ADDR)
    ) u_spi (
        .clk    (clk),
        .rst    (rst),
        .sclk   (ui_in[0]),
        .copi   (ui_in[1]),
        .ncs    (ui_in[2]),
        .en_out (en_out),
        .en_pwm (en_pwm),
        .duty   (duty)
    );

`ifdef UWASIC_PWM_EN
    localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

    logic [PRE_W-1:0] prescale_cnt;
    logic [7:0]       pwm_cnt;
    logic             pwm_sig;

    // Full scale is forced high so duty 0xFF is a true 100%
    assign pwm_sig = (duty == 8'hFF) | (pwm_cnt < duty);

    // Prescaler and 8-bit PWM counter; one full PWM period is 256*PWM_PRESCALE clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_cnt <= '0;
            pwm_cnt      <= '0;
        end else if (prescale_cnt == PRE_W'(PWM_PRESCALE - 1)) begin
            prescale_cnt <= '0;
            pwm_cnt      <= pwm_cnt + 8'd1;
        end else begin
            prescale_cnt <= prescale_cnt + 1'b1;
        end
    end

    // Registered channel mux: disabled -> 0, enabled -> PWM or steady 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan <= '0;
        end else begin
            chan <= en_out & (~en_pwm | {16{pwm_sig}});
        end
    end

    logic unused_pins;
    assign unused_pins = &{1'b0, ena, ui_in[7:3], uio_in};
`else
    // Registered channel outputs follow the enable bits only; PWM registers are kept but inert
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan <= '0;
        end else begin
            chan <= en_out;
        end
    end

    logic unused_pins;
    assign unused_pins = &{1'b0, ena, ui_in[7:3], uio_in, en_pwm, duty};
`endif

    assign uo_out  = chan[7:0];
    assign uio_out = chan[15:8];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_uwasic_onboarding_miranda.sv
module tb_tt_um_uwasic_onboarding_miranda;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic [7:0] ui_in;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    assign ui_in = {5'b00000, ncs, copi, sclk};

    always #5 clk = ~clk;

    tt_um_uwasic_onboarding_miranda dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] exp;
        logic [15:0] mask;
        string       tag;
    } exp_t;
    exp_t sb[$];

    // Reference register file
    logic [7:0] m_regs [5];

    function automatic logic [15:0] m_en_out();
        return {m_regs[1], m_regs[0]};
    endfunction

    // Expected channel value; bits running an intermediate PWM duty are unpredictable at a single sample
    function automatic exp_t m_expect(input string tag);
        exp_t        e;
        logic [15:0] eo;
        logic [15:0] ep;
        eo = m_en_out();
        ep = {m_regs[3], m_regs[2]};
        e.tag  = tag;
`ifdef UWASIC_PWM_EN
        if (m_regs[4] == 8'hFF) begin
            e.exp  = eo;
            e.mask = 16'hFFFF;
        end else if (m_regs[4] == 8'h00) begin
            e.exp  = eo & ~ep;
            e.mask = 16'hFFFF;
        end else begin
            e.exp  = eo & ~ep;
            e.mask = ~(eo & ep);
        end
`else
        e.exp  = eo;
        e.mask = 16'hFFFF;
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            copi = w[15-i];
            wait_clks(4);
            sclk = 1'b1;
            wait_clks(4);
            sclk = 1'b0;
        end
    endtask

    // Send a frame, update the model, then compare 4 clocks after the nCS rise
    task automatic spi_frame(input logic [15:0] w, input int nbits, input string tag);
        exp_t e;
        wait_clks(1);
        ncs = 1'b0;
        wait_clks(4);
        shift_bits(w, nbits);
        wait_clks(4);
        ncs = 1'b1;
        if (nbits == 16 && w[15] && w[14:8] <= 7'd4)
            m_regs[w[10:8]] = w[7:0];
        sb.push_back(m_expect(tag));
        repeat (4) @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check(e.tag, 32'({uio_out, uo_out} & e.mask), 32'(e.exp & e.mask));
        end
    endtask

    // Count high samples of uo_out[0] over exactly one PWM period
    task automatic measure_high(input string tag);
        int highs;
        int exp_highs;
        highs = 0;
        for (int i = 0; i < 3328; i++) begin
            @(negedge clk);
            if (uo_out[0]) highs++;
        end
`ifdef UWASIC_PWM_EN
        exp_highs = (m_regs[4] == 8'hFF) ? 3328 : int'(m_regs[4]) * 13;
`else
        exp_highs = 3328;
`endif
        check(tag, 32'(highs), 32'(exp_highs));
    endtask

    initial begin
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;

        // Reset behaviour
        rst_n = 1'b1;
        wait_clks(5);
        check("reset_during_oe", 32'(uio_oe), 32'hFF);
        check("reset_during_out", 32'({uio_out, uo_out}), 32'h0000);
        rst_n = 1'b0;
        wait_clks(6);
        @(negedge clk);
        check("reset_after_uo", 32'(uo_out), 32'h00);
        check("reset_after_uio", 32'(uio_out), 32'h00);
        check("reset_after_oe", 32'(uio_oe), 32'hFF);

        // Basic writes
        spi_frame(16'h80F0, 16, "write_r0_f0");
        spi_frame(16'h81CC, 16, "write_r1_cc");

        // Rejected frames
        spi_frame(16'h0055, 16, "read_frame_ignored");
        spi_frame(16'hB055, 16, "addr_30_ignored");
        spi_frame(16'h8555, 16, "addr_05_ignored");
        spi_frame(16'h8033, 12, "short_frame_ignored");
        spi_frame(16'h800F, 16, "write_after_short");
        spi_frame(16'h8133, 16, "write_r1_33");

        // Reset in the middle of a frame
        wait_clks(1);
        ncs = 1'b0;
        wait_clks(4);
        shift_bits(16'h8000, 8);
        rst_n = 1'b1;
        #1;
        check("midframe_reset_during", 32'({uio_out, uo_out}), 32'h0000);
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        ncs  = 1'b1;
        sclk = 1'b0;
        wait_clks(3);
        rst_n = 1'b0;
        wait_clks(8);
        @(negedge clk);
        check("midframe_reset_after", 32'({uio_out, uo_out}), 32'h0000);
        spi_frame(16'h8001, 16, "write_after_reset");

        // Shared PWM on channel 0
        spi_frame(16'h8480, 16, "duty_80");
        spi_frame(16'h8201, 16, "en_pwm_0");
        measure_high("pwm_high_duty_80");
`ifdef UWASIC_PWM_EN
        begin
            logic prev;
            bit   found;
            int   period;
            found = 1'b0;
            @(negedge clk);
            prev = uo_out[0];
            for (int i = 0; i < 4000 && !found; i++) begin
                @(negedge clk);
                if (!prev && uo_out[0]) found = 1'b1;
                prev = uo_out[0];
            end
            check("pwm_rise_seen", 32'(found), 32'd1);
            found  = 1'b0;
            period = 0;
            for (int i = 0; i < 4000 && !found; i++) begin
                @(negedge clk);
                period++;
                if (!prev && uo_out[0]) found = 1'b1;
                prev = uo_out[0];
            end
            check("pwm_period", 32'(period), 32'd3328);
        end
`endif
        spi_frame(16'h8400, 16, "duty_00");
        measure_high("pwm_high_duty_00");
        spi_frame(16'h84FF, 16, "duty_ff");
        measure_high("pwm_high_duty_ff");
        check("final_oe", 32'(uio_oe), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tt_um_uwasic_onboarding_miranda.md
TT_UM_UWASIC_ONBOARDING_MIRANDA -- requirements
Module: tt_um_uwasic_onboarding_miranda

Interface
REQ-001 Parameter PWM_PRESCALE, default 13: system clocks per PWM counter step; PWM period = 256*PWM_PRESCALE clocks (3328 clocks, about 3.0 kHz at 10 MHz).
REQ-002 Parameter MAX_ADDR, default 4: highest writable register address.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active-high (asserted at 1; legacy name kept).
REQ-006 ena  input  1  design-selected flag, ignored.
REQ-007 ui_in  input  8  [0]=SCLK, [1]=COPI, [2]=nCS (active-low); [7:3] unused.
REQ-008 uio_in  input  8  unused.
REQ-009 uo_out  output  8  output channels 7..0.
REQ-010 uio_out  output  8  output channels 15..8.
REQ-011 uio_oe  output  8  SHALL be constant 8'hFF.

Function
REQ-012 SCLK, COPI and nCS SHALL each pass through a 2-flop synchronizer in the clk domain; edges SHALL be detected on the synchronized values.
REQ-013 While nCS is low, COPI SHALL be shifted in MSB-first on each synchronized SCLK rising edge (SPI mode 0); the bit count SHALL saturate at 16.
REQ-014 Frame format: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-015 On the synchronized nCS rising edge, the frame SHALL commit only if exactly 16 bits were received, bit15=1 and address <= MAX_ADDR; otherwise it SHALL be discarded without side effects.
REQ-016 A falling edge of nCS SHALL clear the shift register and the bit count; there SHALL be no SPI read-back and no COPO output.
REQ-017 Registers (8-bit): 0x00 en_out[7:0], 0x01 en_out[15:8], 0x02 en_pwm[7:0], 0x03 en_pwm[15:8], 0x04 duty.
REQ-018 A committed write SHALL become visible at the outputs no later than 4 clk cycles after the raw nCS rising edge.
REQ-019 PWM: prescaler counts 0..PWM_PRESCALE-1; pwm_cnt (8-bit) increments and wraps 255->0 on each prescaler wrap.
REQ-020 pwm_sig = 1 when duty==8'hFF, else (pwm_cnt < duty); duty 0x00 SHALL give constant 0.
REQ-021 Channel i output = en_out[i] ? (en_pwm[i] ? pwm_sig : 1) : 0, registered; all 16 channels SHALL share one pwm_sig.

Reset
REQ-022 Reset SHALL clear all registers, synchronizers, shift state, prescaler and pwm_cnt to 0; uo_out and uio_out SHALL be 0 during and after reset.
REQ-023 A frame in progress when reset asserts SHALL be discarded; reset SHALL NOT alter uio_oe.

Configuration
REQ-024 Macro UWASIC_PWM_EN: when defined, REQ-019..REQ-021 apply. When undefined, the PWM counters SHALL be omitted, registers 0x02-0x04 SHALL remain writable but have no effect, and channel i output SHALL equal en_out[i].

Structure
REQ-025 A shared package SHALL hold the register address constants (0x00-0x04), the frame field positions and the 16-bit frame length.
REQ-026 One sub-module, spi_peripheral (synchronizers, shift register, register file), SHALL be used; PWM and output muxing SHALL stay in the top level.

Verification
REQ-027 Reset asserted, then released -> uo_out=0x00, uio_out=0x00, uio_oe=0xFF.
REQ-028 Write 0x00<-0xF0, then 0x01<-0xCC -> uo_out=0xF0, uio_out=0xCC within 4 clocks of each nCS rise.
REQ-029 Frame with bit15=0 (read) to 0x00, and write to address 0x30 -> all registers unchanged.
REQ-030 nCS raised after 12 bits -> frame discarded; the next complete 16-bit write commits normally.
REQ-031 en_out[0]=1, en_pwm[0]=1, duty=0x80 -> uo_out[0] period 3328 clocks, high 1664 clocks (50%); duty=0x00 -> constant 0; duty=0xFF -> constant 1.
REQ-032 Reset asserted mid-frame -> outputs 0; a complete frame after reset release commits.
